counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq.sv | 120 ++++++++++++
 tb/tb_counter_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq.sv
// Rate-divided 8-bit counter sequencer (IDLE/RUN/PAUSE/DONE) that drives an external counter's enable and clear.
// Optional macro COUNTER_SEQ_WRAP_EN adds a registered one-cycle rollover pulse on wrap.
module counter_seq #(
  parameter int DIV_WIDTH = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 mode,
  input  logic [DIV_WIDTH-1:0] div_max,
  input  logic [7:0]           limit,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  output logic [7:0]           count,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Handshake: none. start/stop/clear are level commands sampled on every
  // rising clock edge with priority clear > stop > start; cnt_en and cnt_clr
  // are combinational and take effect on the same edge as count.

  state_t               state_q;
  state_t               state_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;
  logic [7:0]           count_d;
  logic                 tick;
  logic                 clr_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    count_d = count;
    tick    = 1'b0;
    clr_req = 1'b0;
    if (clear) begin
      state_d = IDLE;
      div_d   = '0;
      count_d = '0;
      clr_req = 1'b1;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            div_d   = '0;
          end
        end
        RUN: begin
          // Equality compare only: a div_max lowered below div_q lets the
          // divider run to all-ones and wrap before the next tick.
          if (div_q == div_max) begin
            tick    = 1'b1;
            div_d   = '0;
            count_d = count + 8'd1;
            if (mode && (count_d == limit)) state_d = DONE;
          end else begin
            div_d = div_q + DIV_WIDTH'(1);
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            div_d   = '0;
            count_d = '0;
            clr_req = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cnt_en  = tick & ~reset;
  assign cnt_clr = clr_req | reset;
  assign state   = state_q;
  assign done    = (state_q == DONE);

`ifdef COUNTER_SEQ_WRAP_EN
  logic wrap_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= tick & ~mode & (count == 8'hFF);
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq: reset, divided counting, one-shot, pause/resume,
// command priority, rollover and asynchronous reset mid-run.
module tb_counter_seq;
  localparam int DW = 26;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          clear;
  logic          mode;
  logic [DW-1:0] div_max;
  logic [7:0]    limit;
  logic          cnt_en;
  logic          cnt_clr;
  logic [7:0]    count;
  logic [1:0]    state;
  logic          done;
  logic          wrap;

  int         n_checks = 0;
  int         n_errors = 0;
  int         wrap_seen;
  logic [7:0] exp_q[$];

`ifdef COUNTER_SEQ_WRAP_EN
  localparam logic EXP_WRAP = 1'b1;
`else
  localparam logic EXP_WRAP = 1'b0;
`endif

  counter_seq #(.DIV_WIDTH(DW)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .mode    (mode),
    .div_max (div_max),
    .limit   (limit),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .count   (count),
    .state   (state),
    .done    (done),
    .wrap    (wrap)
  );

  // clock/reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, checks happen 3ns after it
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    mode = 1'b0; div_max = '0; limit = 8'd0;
    #1 reset = 1'b1;
    #2;
    check("rst_state",   state,   32'd0);
    check("rst_count",   count,   32'd0);
    check("rst_cnt_clr", cnt_clr, 32'd1);
    check("rst_cnt_en",  cnt_en,  32'd0);
    check("rst_done",    done,    32'd0);
    check("rst_wrap",    wrap,    32'd0);
    next_cycle();
    reset = 1'b0;
    settle();
    check("post_rst_state", state, 32'd0);

    // divided counting: div_max=3 ticks every 4th RUN cycle
    mode = 1'b0; div_max = DW'(3);
    start = 1'b1;
    settle();
    check("idle_start_en",  cnt_en,  32'd0);
    check("idle_start_clr", cnt_clr, 32'd0);
    next_cycle();
    start = 1'b0;
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1,
              8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    for (int k = 0; k < 16; k++) begin
      settle();
      check("div3_count", count, exp_q.pop_front());
      check("div3_en", cnt_en, (k % 4 == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    div_max = '0;
    settle();
    check("div3_final_count", count, 32'd4);
    check("div3_state", state, 32'd1);
    check("div0_en", cnt_en, 32'd1);
    repeat (3) next_cycle();
    settle();
    check("pre_prio_count", count, 32'd7);

    // all three commands at once: clear wins
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    settle();
    check("prio_clr", cnt_clr, 32'd1);
    check("prio_en", cnt_en, 32'd0);
    next_cycle();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    settle();
    check("prio_state", state, 32'd0);
    check("prio_count", count, 32'd0);
    check("prio_clr_after", cnt_clr, 32'd0);

    // one-shot to limit=5 with div_max=0
    mode = 1'b1; limit = 8'd5; div_max = '0;
    do_start();
    for (int k = 0; k < 5; k++) begin
      settle();
      check("os_count", count, 32'(k));
      check("os_en", cnt_en, 32'd1);
      next_cycle();
    end
    settle();
    check("os_state", state, 32'd3);
    check("os_done", done, 32'd1);
    check("os_count_final", count, 32'd5);
    for (int k = 0; k < 4; k++) begin
      check("done_en", cnt_en, 32'd0);
      check("done_count", count, 32'd5);
      next_cycle();
      settle();
    end
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    settle();
    check("done_stop_state", state, 32'd3);
    start = 1'b1;
    settle();
    check("done_restart_clr", cnt_clr, 32'd1);
    next_cycle();
    start = 1'b0;
    clear = 1'b1;
    settle();
    check("restart_state", state, 32'd1);
    check("restart_count", count, 32'd0);
    check("clear_blocks_en", cnt_en, 32'd0);
    next_cycle();
    clear = 1'b0;

    // one-shot with limit=0 needs a full 256 ticks
    limit = 8'd0;
    do_start();
    repeat (255) next_cycle();
    settle();
    check("lim0_state_255", state, 32'd1);
    check("lim0_count_255", count, 32'd255);
    next_cycle();
    settle();
    check("lim0_state", state, 32'd3);
    check("lim0_count", count, 32'd0);
    check("lim0_done", done, 32'd1);
    do_clear();

    // pause at divider=6 with div_max=9, resume 20 cycles later
    mode = 1'b0; div_max = DW'(9);
    do_start();
    repeat (6) next_cycle();
    stop = 1'b1;
    settle();
    check("stop_en", cnt_en, 32'd0);
    check("stop_state", state, 32'd1);
    next_cycle();
    stop = 1'b0;
    for (int p = 0; p < 20; p++) begin
      settle();
      check("pause_state", state, 32'd2);
      check("pause_count", count, 32'd0);
      check("pause_en", cnt_en, 32'd0);
      next_cycle();
    end
    start = 1'b1;
    settle();
    check("resume_clr", cnt_clr, 32'd0);
    next_cycle();
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      settle();
      check("resume_en", cnt_en, (r == 3) ? 32'd1 : 32'd0);
      check("resume_count", count, 32'd0);
      next_cycle();
    end
    settle();
    check("resume_count_after", count, 32'd1);
    do_clear();

    // free-run rollover with div_max=0
    div_max = '0;
    wrap_seen = 0;
    do_start();
    for (int k = 0; k < 256; k++) begin
      settle();
      check("fr_count", count, 32'(k));
      wrap_seen += int'(wrap);
      next_cycle();
    end
    settle();
    check("fr_wrap_count", count, 32'd0);
    check("fr_wrap_state", state, 32'd1);
    check("fr_wrap_pulse", wrap, 32'(EXP_WRAP));
    check("fr_no_early_wrap", 32'(wrap_seen), 32'd0);
    next_cycle();
    settle();
    check("fr_wrap_gone", wrap, 32'd0);
    check("fr_count_next", count, 32'd1);

    // asynchronous reset between edges mid-run
    next_cycle();
    reset = 1'b1;
    #1;
    check("arst_state", state, 32'd0);
    check("arst_count", count, 32'd0);
    check("arst_clr", cnt_clr, 32'd1);
    check("arst_en", cnt_en, 32'd0);
    check("arst_wrap", wrap, 32'd0);
    start = 1'b1;
    next_cycle();
    settle();
    check("arst_hold_state", state, 32'd0);
    check("arst_hold_clr", cnt_clr, 32'd1);
    reset = 1'b0;
    next_cycle();
    start = 1'b0;
    settle();
    check("post_arst_state", state, 32'd1);
    check("post_arst_count", count, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
